// File: rtl/alu_cmd_sequencer_if.sv
// alu_cmd_sequencer_if: UART byte, ALU operand/result and status signals of the command sequencer
interface alu_cmd_sequencer_if #(
  parameter int DATA_BITS = 8,
  parameter int OP_BITS = 6
);
  logic i_rx_done;
  logic [DATA_BITS-1:0] i_rx_data;
  logic [DATA_BITS-1:0] o_alu_a;
  logic [DATA_BITS-1:0] o_alu_b;
  logic [OP_BITS-1:0] o_alu_op;
  logic [DATA_BITS-1:0] i_alu_result;
  logic i_alu_zero;
  logic i_alu_overflow;
  logic i_alu_carry;
  logic o_tx_start;
  logic [DATA_BITS-1:0] o_tx_data;
  logic i_tx_done;
  logic o_busy;
  logic o_err_timeout;
  logic o_err_opcode;
  logic o_overrun;
  logic [15:0] o_frame_cnt;
  modport master (
    input i_rx_done, i_rx_data, i_alu_result, i_alu_zero, i_alu_overflow, i_alu_carry, i_tx_done,
    output o_alu_a, o_alu_b, o_alu_op, o_tx_start, o_tx_data, o_busy, o_err_timeout, o_err_opcode,
    output o_overrun, o_frame_cnt
  );
  modport slave (
    output i_rx_done, i_rx_data, i_alu_result, i_alu_zero, i_alu_overflow, i_alu_carry, i_tx_done,
    input o_alu_a, o_alu_b, o_alu_op, o_tx_start, o_tx_data, o_busy, o_err_timeout, o_err_opcode,
    input o_overrun, o_frame_cnt
  );
endinterface

// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer: collects A/B/opcode frames from UART, drives the ALU, returns result/flags/status bytes
module alu_cmd_sequencer #(
  parameter int DATA_BITS = 8,
  parameter int OP_BITS = 6,
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input logic clk,
  input logic reset,
  alu_cmd_sequencer_if.master bus
);
  localparam int CW = $clog2(TIMEOUT_CYCLES);
  localparam logic [DATA_BITS-1:0] STA_OK = DATA_BITS'(8'h55);
  localparam logic [DATA_BITS-1:0] STA_BAD = DATA_BITS'(8'hE1);
  typedef enum logic [3:0] {
    IDLE, GET_B, GET_OP, EXEC, SEND_RES, WAIT_RES, SEND_FLG, WAIT_FLG, SEND_STA, WAIT_STA
  } state_e;
  state_e state_q, state_d;
  logic [DATA_BITS-1:0] a_q, a_d, b_q, b_d, tx_q, tx_d, flg_q, flg_d;
  logic [OP_BITS-1:0] op_q, op_d, rx_op;
  logic ok_q, ok_d, tmo_q, tmo_d, ovr_q, ovr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [15:0] frm_q, frm_d;
  logic rx_op_ok, collecting, expired;
  assign rx_op = bus.i_rx_data[OP_BITS-1:0];
  assign rx_op_ok = rx_op inside {OP_BITS'(6'h20), OP_BITS'(6'h22), OP_BITS'(6'h24), OP_BITS'(6'h25),
                                  OP_BITS'(6'h26), OP_BITS'(6'h27), OP_BITS'(6'h03), OP_BITS'(6'h02)};
  assign collecting = state_q inside {GET_B, GET_OP};
  assign expired = collecting && !bus.i_rx_done && cnt_q == CW'(TIMEOUT_CYCLES - 1);
  always_comb begin
    state_d = state_q;
    a_d = a_q;
    b_d = b_q;
    op_d = op_q;
    ok_d = ok_q;
    tx_d = tx_q;
    flg_d = flg_q;
    frm_d = frm_q;
    tmo_d = expired;
    ovr_d = bus.i_rx_done && !(state_q inside {IDLE, GET_B, GET_OP});
    cnt_d = (collecting && !bus.i_rx_done && !expired) ? cnt_q + 1'b1 : '0;
    case (state_q)
      IDLE: if (bus.i_rx_done) begin
        a_d = bus.i_rx_data;
        state_d = GET_B;
      end
      GET_B: if (bus.i_rx_done) begin
        b_d = bus.i_rx_data;
        state_d = GET_OP;
      end
      GET_OP: if (bus.i_rx_done) begin
        ok_d = rx_op_ok;
        op_d = rx_op_ok ? rx_op : op_q;
        state_d = EXEC;
      end
      EXEC: begin
        tx_d = ok_q ? bus.i_alu_result : '0;
        flg_d = ok_q ? {bus.i_alu_zero, bus.i_alu_overflow, bus.i_alu_carry, {(DATA_BITS-3){1'b0}}} : '0;
        state_d = SEND_RES;
      end
      SEND_RES: state_d = WAIT_RES;
      WAIT_RES: if (bus.i_tx_done) begin
        tx_d = flg_q;
        state_d = SEND_FLG;
      end
      SEND_FLG: state_d = WAIT_FLG;
      WAIT_FLG: if (bus.i_tx_done) begin
        tx_d = ok_q ? STA_OK : STA_BAD;
        state_d = SEND_STA;
      end
      SEND_STA: state_d = WAIT_STA;
      WAIT_STA: if (bus.i_tx_done) begin
        frm_d = frm_q + 16'd1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (expired) state_d = IDLE;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      a_q <= '0;
      b_q <= '0;
      op_q <= '0;
      ok_q <= 1'b0;
      tx_q <= '0;
      flg_q <= '0;
      frm_q <= '0;
      tmo_q <= 1'b0;
      ovr_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      a_q <= a_d;
      b_q <= b_d;
      op_q <= op_d;
      ok_q <= ok_d;
      tx_q <= tx_d;
      flg_q <= flg_d;
      frm_q <= frm_d;
      tmo_q <= tmo_d;
      ovr_q <= ovr_d;
      cnt_q <= cnt_d;
    end
  end
  assign bus.o_alu_a = a_q;
  assign bus.o_alu_b = b_q;
  assign bus.o_alu_op = op_q;
  assign bus.o_tx_data = tx_q;
  assign bus.o_tx_start = state_q inside {SEND_RES, SEND_FLG, SEND_STA};
  assign bus.o_busy = state_q != IDLE;
  assign bus.o_err_opcode = state_q == EXEC && !ok_q;
  assign bus.o_err_timeout = tmo_q;
  assign bus.o_overrun = ovr_q;
  assign bus.o_frame_cnt = frm_q;
endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// tb_alu_cmd_sequencer: table, directed and randomized checks of the command sequencer
module tb_alu_cmd_sequencer;
  localparam int TMO = 100;
  typedef struct {
    logic [7:0] a, b, opb, res, flg, sta;
  } vec_t;
  logic clk = 1'b0;
  logic reset;
  int checks = 0;
  int errors = 0;
  int n_eop = 0;
  int n_tmo = 0;
  int n_ovr = 0;
  int tx_lat_max = 2;
  int exp_frames = 0;
  logic [5:0] last_op = '0;
  logic [7:0] txq[$];
  logic [7:0] cap;
  logic [5:0] valid_ops[8] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h03, 6'h02};
  vec_t vecs[12];

  always #5 clk = ~clk;

  alu_cmd_sequencer_if #(.DATA_BITS(8), .OP_BITS(6)) bus ();
  alu_cmd_sequencer #(.DATA_BITS(8), .OP_BITS(6), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  function automatic bit is_valid(input logic [5:0] op);
    return op inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h03, 6'h02};
  endfunction

  // ALU behaviour as plain integer arithmetic: {result, zero, overflow, carry}
  function automatic logic [10:0] ref_alu(input logic [7:0] a, input logic [7:0] b, input logic [5:0] op);
    int s, ss;
    logic [7:0] r;
    logic v, c;
    v = 1'b0;
    c = 1'b0;
    r = '0;
    case (op)
      6'h20: begin
        s = int'(a) + int'(b);
        ss = int'($signed(a)) + int'($signed(b));
        r = 8'(s); c = s > 255; v = ss > 127 || ss < -128;
      end
      6'h22: begin
        s = int'(a) - int'(b);
        ss = int'($signed(a)) - int'($signed(b));
        r = 8'(s); c = s < 0; v = ss > 127 || ss < -128;
      end
      6'h24: r = a & b;
      6'h25: r = a | b;
      6'h26: r = a ^ b;
      6'h27: r = ~(a | b);
      6'h02: r = a >> b[2:0];
      6'h03: r = 8'($signed(a) >>> b[2:0]);
      default: r = '0;
    endcase
    return {r, r == 8'h00, v, c};
  endfunction

  function automatic logic [23:0] model_resp(input logic [7:0] a, input logic [7:0] b, input logic [7:0] opb);
    logic [10:0] r;
    if (!is_valid(opb[5:0])) return {8'h00, 8'h00, 8'hE1};
    r = ref_alu(a, b, opb[5:0]);
    return {r[10:3], r[2], r[1], r[0], 5'b00000, 8'h55};
  endfunction

  always_comb {bus.i_alu_result, bus.i_alu_zero, bus.i_alu_overflow, bus.i_alu_carry} =
    ref_alu(bus.o_alu_a, bus.o_alu_b, bus.o_alu_op);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic rx_byte(input logic [7:0] d);
    @(negedge clk);
    bus.i_rx_data = d;
    bus.i_rx_done = 1'b1;
    @(negedge clk);
    bus.i_rx_done = 1'b0;
  endtask

  task automatic wait_resp(input int base);
    int t;
    t = 0;
    while ((txq.size() < base + 3 || bus.o_busy) && t < 3000) begin
      @(negedge clk);
      t++;
    end
    chk("response_within_budget", t < 3000, 1);
  endtask

  task automatic chk_bytes(input string tag, input int base, input logic [23:0] exp);
    for (int k = 0; k < 3; k++)
      chk({tag, "_tx_byte"}, (base + k < txq.size()) ? 32'(txq[base + k]) : 32'hDEAD, 32'(exp[23 - 8*k -: 8]));
  endtask

  task automatic check_frame(input string tag, input logic [7:0] a, input logic [7:0] b, input logic [7:0] opb,
                             input logic [23:0] exp, input bit stray, input int gap);
    int base, eop0, ovr0, t, starts;
    bit ok;
    base = txq.size();
    eop0 = n_eop;
    ovr0 = n_ovr;
    ok = is_valid(opb[5:0]);
    rx_byte(a);
    idle(gap);
    rx_byte(b);
    idle(gap);
    rx_byte(opb);
    if (stray) begin
      starts = 0;
      t = 0;
      while (starts < 2 && t < 500) begin
        @(negedge clk);
        if (bus.o_tx_start) starts++;
        t++;
      end
      rx_byte(8'h99);
    end
    wait_resp(base);
    chk_bytes(tag, base, exp);
    if (ok) last_op = opb[5:0];
    exp_frames++;
    chk({tag, "_alu_a"}, bus.o_alu_a, a);
    chk({tag, "_alu_b"}, bus.o_alu_b, b);
    chk({tag, "_alu_op"}, bus.o_alu_op, last_op);
    chk({tag, "_err_opcode_pulses"}, n_eop - eop0, !ok);
    chk({tag, "_overrun_pulses"}, n_ovr - ovr0, stray);
    chk({tag, "_frame_cnt"}, bus.o_frame_cnt, exp_frames[15:0]);
  endtask

  initial forever begin
    @(negedge clk);
    n_eop += int'(bus.o_err_opcode);
    n_tmo += int'(bus.o_err_timeout);
    n_ovr += int'(bus.o_overrun);
  end

  // UART transmitter stand-in: records each requested byte, answers after a random latency
  initial begin
    bus.i_tx_done = 1'b0;
    forever begin
      @(negedge clk);
      bus.i_tx_done = 1'b0;
      if (bus.o_tx_start) begin
        cap = bus.o_tx_data;
        txq.push_back(cap);
        @(negedge clk);
        chk("tx_start_one_cycle", bus.o_tx_start, 0);
        repeat ($urandom_range(tx_lat_max, 1) - 1) @(negedge clk);
        if (bus.o_busy) chk("tx_data_stable", bus.o_tx_data, cap);
        bus.i_tx_done = 1'b1;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached, errors so far %0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int base, t0, t;
    logic [7:0] ra, rb, ro;
    bit sendb;
    vecs[0]  = '{8'h05, 8'h03, 8'h20, 8'h08, 8'h00, 8'h55};
    vecs[1]  = '{8'hFF, 8'h01, 8'h20, 8'h00, 8'hA0, 8'h55};
    vecs[2]  = '{8'h12, 8'h34, 8'h3F, 8'h00, 8'h00, 8'hE1};
    vecs[3]  = '{8'h0A, 8'h04, 8'h22, 8'h06, 8'h00, 8'h55};
    vecs[4]  = '{8'h7F, 8'h01, 8'h20, 8'h80, 8'h40, 8'h55};
    vecs[5]  = '{8'hF0, 8'h3C, 8'h24, 8'h30, 8'h00, 8'h55};
    vecs[6]  = '{8'h5A, 8'h5A, 8'h26, 8'h00, 8'h80, 8'h55};
    vecs[7]  = '{8'h0F, 8'hF0, 8'h27, 8'h00, 8'h80, 8'h55};
    vecs[8]  = '{8'h81, 8'h02, 8'hC2, 8'h20, 8'h00, 8'h55};
    vecs[9]  = '{8'h81, 8'h02, 8'h03, 8'hE0, 8'h00, 8'h55};
    vecs[10] = '{8'h0C, 8'h30, 8'h25, 8'h3C, 8'h00, 8'h55};
    vecs[11] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'hE1};
    reset = 1'b1;
    bus.i_rx_done = 1'b0;
    bus.i_rx_data = '0;
    idle(3);
    chk("reset_operands", {bus.o_alu_a, bus.o_alu_b, bus.o_alu_op}, 0);
    chk("reset_ctrl", {bus.o_tx_data, bus.o_tx_start, bus.o_busy, bus.o_err_timeout, bus.o_err_opcode, bus.o_overrun}, 0);
    chk("reset_frame_cnt", bus.o_frame_cnt, 0);
    reset = 1'b0;
    idle(2);
    base = txq.size();
    rx_byte(8'h05);
    rx_byte(8'h03);
    rx_byte(8'h20);
    chk("lat_exec_cycle", {bus.o_busy, bus.o_tx_start}, 2'b10);
    chk("lat_operands", {bus.o_alu_a, bus.o_alu_b, 2'b00, bus.o_alu_op}, 24'h050320);
    @(negedge clk);
    chk("lat_first_start", {bus.o_tx_start, bus.o_tx_data}, 9'h108);
    wait_resp(base);
    chk_bytes("lat", base, 24'h080055);
    exp_frames = 1;
    last_op = 6'h20;
    chk("lat_frame_cnt", bus.o_frame_cnt, 1);
    for (int i = 0; i < 12; i++)
      check_frame("vec", vecs[i].a, vecs[i].b, vecs[i].opb, {vecs[i].res, vecs[i].flg, vecs[i].sta}, 1'b0, i % 4);
    base = txq.size();
    t0 = n_tmo;
    rx_byte(8'h11);
    idle(TMO - 1);
    chk("tmo_last_wait_cycle", {bus.o_busy, bus.o_err_timeout}, 2'b10);
    idle(1);
    chk("tmo_pulse", {bus.o_busy, bus.o_err_timeout}, 2'b01);
    idle(1);
    chk("tmo_pulse_one_cycle", bus.o_err_timeout, 0);
    chk("tmo_pulse_count", n_tmo - t0, 1);
    chk("tmo_no_tx", txq.size(), base);
    chk("tmo_a_kept", bus.o_alu_a, 8'h11);
    check_frame("after_tmo", 8'h0A, 8'h04, 8'h22, 24'h060055, 1'b0, 1);
    t0 = n_tmo;
    check_frame("expiry_edge", 8'h21, 8'h07, 8'h26, 24'h260055, 1'b0, TMO - 2);
    chk("expiry_edge_no_tmo", n_tmo - t0, 0);
    tx_lat_max = 3;
    check_frame("overrun", 8'h33, 8'h44, 8'h20, 24'h770055, 1'b1, 0);
    check_frame("after_overrun", 8'h09, 8'h09, 8'h22, 24'h008055, 1'b0, 0);
    tx_lat_max = 4;
    rx_byte(8'h33);
    rx_byte(8'h44);
    rx_byte(8'h24);
    t = 0;
    while (!bus.o_tx_start && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("rst_reached_send_res", bus.o_tx_start, 1);
    @(negedge clk);
    chk("rst_in_wait_res", {bus.o_busy, bus.o_tx_start}, 2'b10);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("rst_mid_operands", {bus.o_alu_a, bus.o_alu_b, bus.o_alu_op}, 0);
    chk("rst_mid_ctrl", {bus.o_tx_data, bus.o_tx_start, bus.o_busy, bus.o_err_timeout, bus.o_err_opcode, bus.o_overrun}, 0);
    chk("rst_mid_frame_cnt", bus.o_frame_cnt, 0);
    @(negedge clk);
    chk("rst_mid_no_start", {bus.o_tx_start, bus.o_busy}, 0);
    exp_frames = 0;
    last_op = '0;
    idle(6);
    check_frame("after_rst", 8'h05, 8'h03, 8'h20, 24'h080055, 1'b0, 0);
    for (int i = 0; i < 40; i++) begin
      tx_lat_max = $urandom_range(4, 1);
      ra = 8'($urandom);
      rb = 8'($urandom);
      ro = ($urandom_range(3, 0) != 0) ? {2'($urandom), valid_ops[$urandom_range(7, 0)]} : 8'($urandom);
      if ($urandom_range(9, 0) == 0) begin
        base = txq.size();
        t0 = n_tmo;
        sendb = 1'($urandom);
        rx_byte(ra);
        if (sendb) rx_byte(rb);
        idle(TMO + 1);
        chk("rand_abandon_tmo", n_tmo - t0, 1);
        chk("rand_abandon_idle", bus.o_busy, 0);
        chk("rand_abandon_no_tx", txq.size(), base);
        chk("rand_abandon_a", bus.o_alu_a, ra);
        if (sendb) chk("rand_abandon_b", bus.o_alu_b, rb);
      end else begin
        check_frame("rand", ra, rb, ro, model_resp(ra, rb, ro), 1'b0, $urandom_range(3, 0));
      end
    end
    idle(4);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/alu_cmd_sequencer.md
# alu_cmd_sequencer

Command sequencer between the UART byte interfaces (`uart_rx` / `uart_tx`) and the `alu` datapath. It collects a 3-byte command frame (A, B, opcode) and drives the ALU operands. It returns a 3-byte response (result, flags, status) and adds inter-byte timeout, opcode validation, overrun reporting and a completed-frame counter. It replaces the ad-hoc control FSM in the UART/ALU top level; `baud_rate_generator`, `uart_rx`, `uart_tx` and `alu` stay unchanged.

## Interface
- DATA_BITS, 8, operand/result width; must equal `uart_rx`/`uart_tx` byte width
- OP_BITS, 6, opcode width; low OP_BITS of the third byte
- TIMEOUT_CYCLES, 1_000_000, max clk cycles between frame bytes (10 ms at 100 MHz); must be >= 2

Ports:
- clk  in  1  system clock; all logic on rising edge
- reset  in  1  synchronous, active-high
- i_rx_done  in  1  one-cycle pulse, byte available on i_rx_data
- i_rx_data  in  DATA_BITS  received byte, valid with i_rx_done
- o_alu_a  out  DATA_BITS  operand A register
- o_alu_b  out  DATA_BITS  operand B register
- o_alu_op  out  OP_BITS  opcode register
- i_alu_result  in  DATA_BITS  combinational ALU result
- i_alu_zero, i_alu_overflow, i_alu_carry  in  1 each  ALU flags
- o_tx_start  out  1  one-cycle transmit request
- o_tx_data  out  DATA_BITS  byte to transmit; stable from o_tx_start until i_tx_done
- i_tx_done  in  1  one-cycle pulse, transmitter finished the byte
- o_busy  out  1  high in every state except IDLE
- o_err_timeout  out  1  one-cycle pulse, partial frame discarded
- o_err_opcode  out  1  one-cycle pulse, invalid opcode received
- o_overrun  out  1  one-cycle pulse, byte received while responding (byte dropped)
- o_frame_cnt  out  16  count of completed responses; wraps 0xFFFF -> 0x0000

## Operation
- States:
  - IDLE: on i_rx_done, latch A and go to GET_B.
  - GET_B: on i_rx_done, latch B and go to GET_OP.
  - GET_OP: on i_rx_done, latch op and go to EXEC.
  - EXEC: capture i_alu_result and the flags into internal hold registers, then go to SEND_RES.
  - SEND_RES -> WAIT_RES -> SEND_FLG -> WAIT_FLG -> SEND_STA -> WAIT_STA -> IDLE.
- Response sequence:
  - Each SEND_x state lasts exactly 1 cycle.
  - Each WAIT_x state holds until i_tx_done.
- Valid opcodes: 0x20 ADD, 0x22 SUB, 0x24 AND, 0x25 OR, 0x26 XOR, 0x27 NOR, 0x03 SRA, 0x02 SRL.
- Response bytes:
  - Valid opcode: result = held result; flags = {zero, overflow, carry, 5'b0}; status = 0x55.
  - Invalid opcode: result = 0x00, flags = 0x00, status = 0xE1; o_err_opcode pulses in EXEC.
  - Invalid opcode does not change o_alu_op; the last valid opcode is kept.
- Byte interface:
  - Operands are latched on the same edge as i_rx_done.
  - o_alu_a/b/op hold their value until the next frame overwrites them.
- Timeout:
  - A cycle counter clears on entry to GET_B and on every accepted byte.
  - In GET_B or GET_OP, reaching TIMEOUT_CYCLES-1 with no i_rx_done: go to IDLE, pulse o_err_timeout, send no response.
  - Operands already latched keep their values.
- Simultaneous events:
  - i_rx_done on the timeout-expiry cycle: the byte is accepted; no timeout.
  - i_rx_done in EXEC, SEND_x or WAIT_x: the byte is ignored and o_overrun pulses.
  - i_tx_done outside WAIT_x is ignored.
- o_frame_cnt increments on the WAIT_STA -> IDLE transition, for both valid and invalid frames.

## Timing
- Reset values: state IDLE; o_alu_a/b/op = 0; o_tx_start = 0; o_tx_data = 0x00; o_busy = 0; all error pulses = 0; o_frame_cnt = 0; timeout counter = 0.
- Reset mid-frame or mid-response: immediately IDLE; o_tx_start not asserted on the reset cycle or on the cycle after it.
- All outputs are registered or decoded from state only (Moore); no combinational path from i_* to o_*.
- o_tx_start = 1 exactly in SEND_RES, SEND_FLG and SEND_STA.
- o_tx_data is loaded on entry to each SEND_x and held through the matching WAIT_x.
- Latency: opcode i_rx_done at edge T -> EXEC in cycle T+1 -> o_tx_start with result byte in cycle T+2.
- Next-byte latency: i_tx_done in WAIT_x at edge N -> next SEND_x in cycle N+1.
- After the WAIT_STA i_tx_done, IDLE accepts a new byte on the next cycle.

## Test plan
- Frame A=0x05, B=0x03, op=0x20 -> ALU sees A=0x05, B=0x03, op=0x20; tx bytes 0x08, 0x00, 0x55; o_frame_cnt 0->1; o_tx_start high 1 cycle each, first at T+2.
- A=0xFF, B=0x01, op=0x20 -> tx 0x00, 0xA0 (zero=1, carry=1; overflow=0 for signed -1+1), 0x55.
- Invalid op 0x3F -> o_err_opcode pulse; tx 0x00, 0x00, 0xE1; o_alu_op keeps previous value; o_frame_cnt increments.
- Timeout, TIMEOUT_CYCLES=100:
  - send A only; after 100 idle cycles -> o_err_timeout pulse, IDLE, no o_tx_start.
  - then send a full frame (0x0A, 0x04, 0x22) -> response 0x06, 0x00, 0x55.
- Stray byte during WAIT_FLG -> o_overrun pulse; response unchanged; next frame decodes correctly.
- Reset asserted during WAIT_RES -> outputs at reset values next cycle; o_frame_cnt = 0; a subsequent frame completes normally.
